// File: rtl/rock_setpoint_ctrl_pkg.sv
// Shared defaults and types for the cradle-drive setpoint controller.
package rock_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_A_INIT  = 5;
    localparam int DEF_F_INIT  = 5;
    localparam int DEF_HOLDOFF = 1000;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN
    } step_t;

    // A hold-off of 0 still needs a one-bit (always zero) timer register.
    function automatic int ho_width(input int holdoff);
        return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
    endfunction

endpackage

// File: rtl/rock_step_counter.sv
// One setpoint channel: rising-edge request detect, hold-off timer and a
// saturating up/down count that never wraps.
module rock_step_counter
    import rock_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int INIT    = DEF_A_INIT,
    parameter int MAX     = (2 ** DEF_WIDTH) - 1,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic             i_up,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_count_next
);

    localparam int               HO_W    = ho_width(HOLDOFF);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH + 1)'(MAX);
    localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);
    localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF);

    if (INIT > MAX || MAX >= (1 << WIDTH) || INIT < 0) begin : g_bad_params
        $error("rock_step_counter: INIT must be <= MAX and MAX < 2**WIDTH");
    end

    logic             r_up_q;
    logic             r_down_q;
    logic [HO_W-1:0]  r_ho;
    logic [WIDTH-1:0] r_count;

    logic             w_up_ev;
    logic             w_down_ev;
    logic             w_open;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [HO_W-1:0]  w_ho_next;
    logic [WIDTH-1:0] w_count_next;
    step_t            w_step;

    assign w_up_ev   = i_up & ~r_up_q;
    assign w_down_ev = i_down & ~r_down_q;
    assign w_open    = (r_ho == '0);
    assign w_inc     = {1'b0, r_count} + (WIDTH + 1)'(1);
    assign w_dec     = {1'b0, r_count} - (WIDTH + 1)'(1);

    // Simultaneous up and down cancel each other and leave the timer idle.
    always_comb begin
        w_step = STEP_NONE;
        if (!i_init && w_open && (w_up_ev != w_down_ev)) begin
            w_step = w_up_ev ? STEP_UP : STEP_DOWN;
        end
    end

    always_comb begin
        w_count_next = r_count;
        w_ho_next    = r_ho;
        if (i_init) begin
            w_count_next = INIT_V;
            w_ho_next    = '0;
        end else begin
            case (w_step)
                STEP_UP: begin
                    w_count_next = (w_inc > MAX_X) ? MAX_X[WIDTH-1:0] : w_inc[WIDTH-1:0];
                    w_ho_next    = HO_LOAD;
                end
                STEP_DOWN: begin
                    // Borrow out of the extended result means we were already at 0.
                    w_count_next = w_dec[WIDTH] ? '0 : w_dec[WIDTH-1:0];
                    w_ho_next    = HO_LOAD;
                end
                default: begin
                    if (!w_open) begin
                        w_ho_next = r_ho - HO_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_q   <= 1'b0;
            r_down_q <= 1'b0;
            r_ho     <= '0;
            r_count  <= INIT_V;
        end else begin
            r_up_q   <= i_up;
            r_down_q <= i_down;
            r_ho     <= w_ho_next;
            r_count  <= w_count_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_next;

endmodule

// File: rtl/rock_setpoint_ctrl.sv
// Amplitude/frequency setpoint controller: two independent step channels plus
// registered zero flags and a change strobe aligned with the setpoints.
module rock_setpoint_ctrl
    import rock_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int A_INIT  = DEF_A_INIT,
    parameter int F_INIT  = DEF_F_INIT,
    parameter int A_MAX   = (2 ** WIDTH) - 1,
    parameter int F_MAX   = (2 ** WIDTH) - 1,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init,
    input  logic             Ahoog,
    input  logic             Alaag,
    input  logic             Fhoog,
    input  logic             Flaag,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] F,
    output logic             F0,
    output logic             AF0,
    output logic             changed
);

    localparam logic F0_RST  = (F_INIT == 0);
    localparam logic AF0_RST = (A_INIT == 0) && (F_INIT == 0);

    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_f_next;
    logic             r_f0;
    logic             r_af0;
    logic             r_changed;

    rock_step_counter #(
        .WIDTH   (WIDTH),
        .INIT    (A_INIT),
        .MAX     (A_MAX),
        .HOLDOFF (HOLDOFF)
    ) u_amp (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_init       (init),
        .i_up         (Ahoog),
        .i_down       (Alaag),
        .o_count      (A),
        .o_count_next (w_a_next)
    );

    rock_step_counter #(
        .WIDTH   (WIDTH),
        .INIT    (F_INIT),
        .MAX     (F_MAX),
        .HOLDOFF (HOLDOFF)
    ) u_freq (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_init       (init),
        .i_up         (Fhoog),
        .i_down       (Flaag),
        .o_count      (F),
        .o_count_next (w_f_next)
    );

    // Flags come from next-state values so they update on the same edge as A/F.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f0      <= F0_RST;
            r_af0     <= AF0_RST;
            r_changed <= 1'b0;
        end else begin
            r_f0      <= (w_f_next == '0);
            r_af0     <= (w_a_next == '0) && (w_f_next == '0);
            r_changed <= (w_a_next != A) || (w_f_next != F);
        end
    end

    assign F0      = r_f0;
    assign AF0     = r_af0;
    assign changed = r_changed;

endmodule
